shift_gather: RTL and testbench
===============================

SHIFT_GATHER -- requirements
Module: shift_gather

Interface
REQ-001 Parameter: WIDTH, 8, bits per byte lane.
REQ-002 Parameter: DEPTH, 32, byte lanes per frame (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 in_byte  input  WIDTH  serial byte stream, most-significant lane of frame first.
REQ-006 in_valid  input  1  in_byte holds a valid byte this cycle.
REQ-007 in_ready  output  1  block accepts in_byte this cycle.
REQ-008 flush  input  1  synchronous discard of partial or held frame.
REQ-009 frame  output  WIDTH*DEPTH  assembled parallel frame; lane k = frame[k*WIDTH +: WIDTH].
REQ-010 frame_valid  output  1  frame holds DEPTH complete bytes.
REQ-011 frame_ready  input  1  consumer takes frame this cycle.
REQ-012 level  output  log2(DEPTH)+1  bytes currently held (0..DEPTH).
REQ-013 overrun  output  1  sticky: byte offered while in_ready=0.

Function
REQ-014 Byte accepted on rising edge where in_valid=1 and in_ready=1.
REQ-015 On accept: frame shifts up one lane (lane k <= lane k-1), lane 0 <= in_byte; level increments by 1.
REQ-016 After DEPTH accepts, first accepted byte in lane DEPTH-1, last in lane 0 (inverse of the lane-DEPTH-1-first serial output order of the existing parallel-to-serial chain).
REQ-017 Two states: COLLECT (in_ready=1, frame_valid=0), HOLD (in_ready=0, frame_valid=1).
REQ-018 COLLECT -> HOLD on the accept that brings level to DEPTH; frame_valid=1 the following cycle (latency 1 clk from final byte).
REQ-019 HOLD -> COLLECT on edge with frame_ready=1; level <= 0; frame contents retained but no longer valid.
REQ-020 In HOLD, frame and level shall not change except via REQ-019, flush or reset.
REQ-021 in_ready combinational from state only; never depends on in_valid or frame_ready (no bypass: byte offered in release cycle not accepted).
REQ-022 frame_ready ignored in COLLECT.
REQ-023 overrun <= 1 on any edge with in_valid=1 and in_ready=0; held until flush or reset.
REQ-024 flush=1: state <= COLLECT, level <= 0, overrun <= 0, frame <= 0; priority over accept and frame_ready same cycle.
REQ-025 level wraps never: range strictly 0..DEPTH; level=DEPTH only in HOLD.
REQ-026 No combinational path from in_valid/in_byte to any output.

Reset
REQ-027 rst=0 asynchronously forces: state COLLECT, frame=0, level=0, frame_valid=0, in_ready=1 (after release), overrun=0.
REQ-028 Reset mid-frame or in HOLD discards all bytes; first accept after release lands as byte 1 of new frame.
REQ-029 While rst=0, in_ready=0 and no byte accepted.

Verification
REQ-030 Reset, stream bytes 0x1F,0x1E,...,0x00 (32, in_valid=1 every cycle) -> frame_valid=1 one clk after 0x00 accepted; lane 31=0x1F, lane 0=0x00; level=32.
REQ-031 Same stream with in_valid toggling 1/0 each cycle -> identical frame, frame_valid after 64 cycles, level tracks accepts.
REQ-032 HOLD with frame_ready=0 for 10 clks while in_valid=1 -> frame stable, in_ready=0, overrun=1; then frame_ready=1 -> frame_valid=0, level=0, next byte lands lane 0.
REQ-033 After 12 bytes assert flush together with in_valid=1 -> level=0, frame=0, overrun=0, byte not accepted; next 32 bytes form correct frame.
REQ-034 Assert rst=0 asynchronously (between edges) after 20 bytes -> outputs reset immediately; after release 32 new bytes 0xA0..0xBF -> lane 31=0xA0, lane 0=0xBF.
REQ-035 Back-to-back: frame_ready held 1, in_valid held 1 for 66 clks -> exactly two frames, each released one clk after frame_valid rises, one byte skipped per release cycle.

Source files
------------

// File: rtl/shift_gather.sv
// Serial-to-parallel frame gatherer: shifts WIDTH-bit bytes into a DEPTH-lane frame
// and holds the completed frame until the consumer takes it.
module shift_gather #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [WIDTH-1:0]         in_byte_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic                     flush_i,
   output logic [WIDTH*DEPTH-1:0]   frame_o,
   output logic                     frame_valid_o,
   input  logic                     frame_ready_i,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overrun_o
);

   localparam int unsigned LvlW = $clog2(DEPTH) + 1;
   localparam logic [LvlW-1:0] LastLvl = LvlW'(DEPTH - 1);

   typedef enum logic {StCollect, StHold} state_e;

   state_e                   state_q, state_d;
   logic [WIDTH*DEPTH-1:0]   frame_q, frame_d;
   logic [LvlW-1:0]          level_q, level_d;
   logic                     overrun_q, overrun_d;
   logic                     in_ready;
   logic                     accept;

   assign accept = in_valid_i & in_ready;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StCollect;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StCollect: if (accept && (level_q == LastLvl)) state_d = StHold;
         StHold:    if (frame_ready_i) state_d = StCollect;
         default:   state_d = StCollect;
      endcase
      if (flush_i) state_d = StCollect;
   end

   // Outputs depend on state only; ready is held low while reset is asserted
   always_comb begin
      in_ready      = (state_q == StCollect) & rst_ni;
      frame_valid_o = (state_q == StHold);
   end

   assign in_ready_o = in_ready;
   assign frame_o    = frame_q;
   assign level_o    = level_q;
   assign overrun_o  = overrun_q;

   always_comb begin
      frame_d   = frame_q;
      level_d   = level_q;
      overrun_d = overrun_q | (in_valid_i & ~in_ready);
      if (flush_i) begin
         frame_d   = '0;
         level_d   = '0;
         overrun_d = 1'b0;
      end else if (accept) begin
         frame_d = {frame_q[WIDTH*(DEPTH-1)-1:0], in_byte_i};
         level_d = level_q + LvlW'(1);
      end else if ((state_q == StHold) && frame_ready_i) begin
         // Release keeps the old contents visible but marks the frame empty
         level_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_q   <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         frame_q   <= frame_d;
         level_q   <= level_d;
         overrun_q <= overrun_d;
      end
   end

endmodule

// File: tb/tb_shift_gather.sv
// Directed self-checking bench for shift_gather with hand-derived frame contents.
module tb_shift_gather;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 32;

   logic                   clk;
   logic                   rst_n;
   logic [WIDTH-1:0]       in_byte;
   logic                   in_valid;
   logic                   in_ready;
   logic                   flush;
   logic [WIDTH*DEPTH-1:0] frame;
   logic                   frame_valid;
   logic                   frame_ready;
   logic [5:0]             level;
   logic                   overrun;

   int unsigned n_vec;
   int unsigned n_err;
   logic [WIDTH*DEPTH-1:0] exp_f;
   logic [WIDTH*DEPTH-1:0] snap_f;
   int unsigned            fv_cnt;

   shift_gather #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .in_byte_i     (in_byte),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .flush_i       (flush),
      .frame_o       (frame),
      .frame_valid_o (frame_valid),
      .frame_ready_i (frame_ready),
      .level_o       (level),
      .overrun_o     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; in_byte = '0; in_valid = 1'b0; flush = 1'b0; frame_ready = 1'b0;
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_level", level, 0);
      chk("rst_frame", frame, 0);
      chk("rst_fvalid", frame_valid, 0);
      chk("rst_overrun", overrun, 0);
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1);

      // Full-rate stream 0x1F..0x00: lane k ends up holding k
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1; in_byte = 8'(31 - i);
         step();
         if (i == 15) chk("s1_level16", level, 16);
         if (i == 30) chk("s1_fvalid_early", frame_valid, 0);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 32; k++) exp_f[k*8 +: 8] = 8'(k);
      chk("s1_fvalid", frame_valid, 1);
      chk("s1_frame", frame, exp_f);
      chk("s1_level32", level, 32);
      chk("s1_in_ready", in_ready, 0);
      chk("s1_overrun", overrun, 0);

      // Hold with data offered: frame frozen, overrun set
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_byte = 8'hC3;
         step();
      end
      chk("hold_frame", frame, exp_f);
      chk("hold_level", level, 32);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_overrun", overrun, 1);
      in_valid = 1'b0; frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      chk("rel_fvalid", frame_valid, 0);
      chk("rel_level", level, 0);
      chk("rel_ready", in_ready, 1);
      chk("rel_frame_kept", frame, exp_f);
      in_valid = 1'b1; in_byte = 8'h55;
      step();
      exp_f = {exp_f[247:0], 8'h55};
      chk("next_lane0", frame, exp_f);
      chk("next_level", level, 1);
      chk("overrun_sticky", overrun, 1);

      // Flush after 12 bytes total
      for (int i = 0; i < 11; i++) begin
         in_byte = 8'(i + 1);
         step();
      end
      chk("pre_flush_level", level, 12);
      flush = 1'b1; in_byte = 8'hEE;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_level", level, 0);
      chk("flush_frame", frame, 0);
      chk("flush_overrun", overrun, 0);
      chk("flush_ready", in_ready, 1);

      // Half-rate stream after flush
      for (int c = 0; c < 64; c++) begin
         in_valid = (c % 2 == 0);
         in_byte = 8'(31 - c / 2);
         step();
         if (c == 1) chk("s2_level1", level, 1);
         if (c == 61) chk("s2_level31", level, 31);
         if (c == 61) chk("s2_fvalid_early", frame_valid, 0);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 32; k++) exp_f[k*8 +: 8] = 8'(k);
      chk("s2_fvalid", frame_valid, 1);
      chk("s2_frame", frame, exp_f);
      chk("s2_level", level, 32);
      chk("s2_overrun", overrun, 0);

      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;

      // Asynchronous reset mid-frame
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; in_byte = 8'(i + 8'h40);
         step();
      end
      chk("pre_rst_level", level, 20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_level", level, 0);
      chk("arst_frame", frame, 0);
      chk("arst_ready", in_ready, 0);
      step(); step();
      chk("arst_hold_level", level, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         in_byte = 8'(8'hA0 + i);
         step();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 32; k++) exp_f[k*8 +: 8] = 8'(8'hA0 + 31 - k);
      chk("s3_frame", frame, exp_f);
      chk("s3_level", level, 32);
      chk("s3_fvalid", frame_valid, 1);

      // Flush out of hold, then back-to-back frames
      flush = 1'b1; frame_ready = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_hold_fvalid", frame_valid, 0);
      chk("flush_hold_frame", frame, 0);
      fv_cnt = 0;
      for (int c = 0; c < 66; c++) begin
         in_valid = 1'b1; in_byte = 8'(c); frame_ready = 1'b1;
         step();
         if (frame_valid) fv_cnt++;
         if (c == 31) begin
            for (int k = 0; k < 32; k++) exp_f[k*8 +: 8] = 8'(31 - k);
            chk("b2b_frame1", frame, exp_f);
         end
         if (c == 32) chk("b2b_release1", frame_valid, 0);
         if (c == 64) begin
            for (int k = 0; k < 32; k++) exp_f[k*8 +: 8] = 8'(64 - k);
            snap_f = exp_f;
            chk("b2b_frame2", frame, exp_f);
         end
      end
      in_valid = 1'b0; frame_ready = 1'b0;
      chk("b2b_count", fv_cnt, 2);
      chk("b2b_level", level, 0);
      chk("b2b_fvalid", frame_valid, 0);
      chk("b2b_frame_kept", frame, snap_f);
      chk("b2b_overrun", overrun, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
